div_u26_u10_arbiter: RTL

//  Shares one pipelined unsigned divider (26-bit dividend / 10-bit divisor) among NREQ requesters.

---
 rtl/div_u26_u10_arbiter_pkg.sv | 15 +
 rtl/div_u26_u10_arbiter_tag_pipe.sv | 56 +++++
 rtl/div_u26_u10_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_u26_u10_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin divider arbiter.
// Widths are parameters of the modules; this package supplies their defaults.
package div_u26_u10_arbiter_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DVD_W   = 26;
  localparam int DEF_DVS_W   = 10;
  localparam int DEF_DIV_LAT = 26;

  // Requester-ID width; at least one bit so single-field tags stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_u26_u10_arbiter_tag_pipe.sv
// Enabled shift register carrying {valid, id, dz, dividend_lo} alongside the divider,
// so each divider result can be matched to its owner and its divide-by-zero fixup.
module div_u26_u10_arbiter_tag_pipe #(
  parameter int DEPTH = 26,
  parameter int ID_W  = 2,
  parameter int LO_W  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            dz_i,
  input  logic [LO_W-1:0] lo_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o,
  output logic            dz_o,
  output logic [LO_W-1:0] lo_o,
  output logic            any_valid_o
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            dz;
    logic [LO_W-1:0] lo;
  } tag_data_t;

  logic [DEPTH-1:0] valid_q;
  tag_data_t        data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= (valid_q << 1) | DEPTH'(valid_i);
    end
  end

  // NOTE: only the valid bits are reset; the payload is ignored unless its valid bit
  // is set, so the data array stays a plain register file with no reset fan-out.
  always_ff @(posedge clk) begin
    if (en) begin
      data_q[0] <= '{id: id_i, dz: dz_i, lo: lo_i};
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign id_o        = data_q[DEPTH-1].id;
  assign dz_o        = data_q[DEPTH-1].dz;
  assign lo_o        = data_q[DEPTH-1].lo;
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/div_u26_u10_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned divider among NREQ requesters;
// a tag pipe routes each registered result back to the requester that issued it.
module div_u26_u10_arbiter
  import div_u26_u10_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DVD_W   = DEF_DVD_W,
  parameter int DVS_W   = DEF_DVS_W,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DVD_W-1:0]   req_dividend,
  input  logic [NREQ*DVS_W-1:0]   req_divisor,
  output logic [NREQ-1:0]         resp_valid,
  output logic [DVD_W-1:0]        resp_quotient,
  output logic [DVS_W-1:0]        resp_remain,
  output logic                    resp_dz,
  output logic                    busy,
  output logic                    div_clken,
  output logic [DVD_W-1:0]        div_numer,
  output logic [DVS_W-1:0]        div_denom,
  input  logic [DVD_W-1:0]        div_quotient,
  input  logic [DVS_W-1:0]        div_remain
);

  localparam int ID_W = id_width(NREQ);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             issue_dz;

  logic             tag_valid, tag_dz, tag_any;
  logic [ID_W-1:0]  tag_id;
  logic [DVS_W-1:0] tag_lo;

  logic [NREQ-1:0]  resp_valid_q;
  logic [DVD_W-1:0] resp_quotient_q;
  logic [DVS_W-1:0] resp_remain_q;
  logic             resp_dz_q;

  // Scan from the pointer, wrapping, and take the first active request.
  // NOTE: every output of this block gets a default before the loop so no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
    if (!(en && rst_n)) win_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    div_numer = '0;
    div_denom = '0;
    if (win_found) begin
      req_ready[win_id] = 1'b1;
      div_numer         = req_dividend[int'(win_id)*DVD_W +: DVD_W];
      div_denom         = req_divisor[int'(win_id)*DVS_W +: DVS_W];
    end
  end

  assign issue_dz = (div_denom == '0);
  assign ptr_d    = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;

  div_u26_u10_arbiter_tag_pipe #(
    .DEPTH (DIV_LAT),
    .ID_W  (ID_W),
    .LO_W  (DVS_W)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .valid_i     (win_found),
    .id_i        (win_id),
    .dz_i        (issue_dz),
    .lo_i        (div_numer[DVS_W-1:0]),
    .valid_o     (tag_valid),
    .id_o        (tag_id),
    .dz_o        (tag_dz),
    .lo_o        (tag_lo),
    .any_valid_o (tag_any)
  );

  // Output register: the strobe lasts one enabled cycle, the data bus holds its last value.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= '0;
      resp_valid_q    <= '0;
      resp_quotient_q <= '0;
      resp_remain_q   <= '0;
      resp_dz_q       <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (en) begin
        if (win_found) ptr_q <= ptr_d;
        if (tag_valid) begin
          resp_valid_q[tag_id] <= 1'b1;
          resp_dz_q            <= tag_dz;
          if (tag_dz) begin
            resp_quotient_q <= '1;
            resp_remain_q   <= tag_lo;
          end else begin
            resp_quotient_q <= div_quotient;
            resp_remain_q   <= div_remain;
          end
        end
      end
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_remain   = resp_remain_q;
  assign resp_dz       = resp_dz_q;
  assign busy          = tag_any | (|resp_valid_q);
  assign div_clken     = en;

endmodule
